cva6_mem_req_arbiter: RTL and testbench
=======================================

# cva6_mem_req_arbiter

Two-requester memory request arbiter between the instruction-cache refill path and the write-through data-cache miss/write path and the single shared memory request port in front of the AXI adapter. It grants one request per cycle round-robin, registers the winner in a one-entry output stage, and tags it with a source bit plus the requester transaction ID. It enforces a per-requester outstanding-transaction limit and routes responses back by ID.

## Interface
- AddrWidth, 64, request address width
- DataWidth, 64, write/response data width
- TidWidth, 2, requester transaction ID width
- MaxOutstanding, 7, maximum in-flight transactions per requester (1..15)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- icache_req_valid_i / icache_req_ready_o  in/out  1  icache request handshake
- icache_req_addr_i  in  AddrWidth  icache read address
- icache_req_tid_i  in  TidWidth  icache transaction ID
- dcache_req_valid_i / dcache_req_ready_o  in/out  1  dcache request handshake
- dcache_req_addr_i  in  AddrWidth  dcache address
- dcache_req_we_i  in  1  dcache write enable
- dcache_req_wdata_i  in  DataWidth  dcache write data
- dcache_req_tid_i  in  TidWidth  dcache transaction ID
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake
- mem_req_addr_o  out  AddrWidth; mem_req_we_o  out  1; mem_req_wdata_o  out  DataWidth
- mem_req_id_o  out  TidWidth+1  {source, tid}; source 0 = icache, 1 = dcache
- mem_rsp_valid_i  in  1; mem_rsp_id_i  in  TidWidth+1; mem_rsp_data_i  in  DataWidth
- icache_rsp_valid_o, dcache_rsp_valid_o  out  1  routed response strobes
- icache_rsp_tid_o, dcache_rsp_tid_o  out  TidWidth; icache_rsp_data_o, dcache_rsp_data_o  out  DataWidth
- idle_o  out  1  output stage empty and both counters zero
- err_o  out  1  sticky: response received for a source with zero outstanding

## Operation
- FSM states: EMPTY (no held request) and HELD (request in output stage). Transition EMPTY->HELD on a grant. HELD->EMPTY on mem handshake with no new grant. HELD->HELD on mem handshake with a new grant.
- Stage can accept = EMPTY or (HELD and mem_req_ready_i). Requester X is eligible when valid_i is high and cnt_X < MaxOutstanding.
- X_req_ready_o = can accept, and X eligible-capable (cnt_X < MaxOutstanding), and X is the winner or the other requester is not valid.
- Round-robin: the pointer starts at icache and moves to the non-granted requester after every grant. A single eligible requester always wins.
- Icache requests drive we=0 and wdata=0.
- Counters cnt_I/cnt_D, width $clog2(MaxOutstanding+1). Each increments on requester handshake and decrements on mem_rsp_valid_i with matching source. Simultaneous increment and decrement leaves the value unchanged. A decrement at zero saturates at 0 and sets err_o.
- Response routing is combinational. mem_rsp_id_i MSB selects the target. tid = low bits, and data passes through. Responses have no backpressure.

## Timing
- Grant in cycle N -> mem_req_valid_o high from N+1. Payload is stable until the mem handshake.
- Back-to-back: a continuously ready memory port sustains one request per cycle.
- Response latency is 0 cycles, from mem_rsp_valid_i to X_rsp_valid_o.
- Reset values: mem_req_valid_o=0, all payload outputs 0, counters 0, pointer=icache, err_o=0, idle_o=1. Both req_ready_o are forced to 0 while rst_i is high.
- Reset mid-operation drops the held request and clears the counters. Responses still in flight are not tracked.
- With cnt_X == MaxOutstanding, a response for X in the same cycle does not open ready. Ready reopens in the next cycle.

## Configuration
- CVA6_MEM_ARB_DCACHE_PRIO_EN defined: fixed priority, with dcache always winning over icache. The pointer is removed.
- Undefined: round-robin as above.

## Test plan
- Single icache request: addr=0x8000_0000, tid=1, mem ready -> mem_req_valid_o in next cycle with id=3'b001 and we=0; cnt_I=1; response id=3'b001 with data 0xDEAD -> icache_rsp_valid_o, tid=1, data=0xDEAD, same cycle; idle_o returns to 1.
- Both requesters continuously valid, mem always ready -> grants alternate I,D,I,D. With the macro defined -> only D is granted.
- mem_req_ready_i low for 5 cycles with a request held -> payload is stable and both req_ready_o are 0. When ready rises, the next grant issues in the same cycle.
- Issue 7 dcache requests with no responses -> dcache_req_ready_o=0 after the 7th. One dcache response -> ready is 1 in the following cycle.
- Response id=3'b000 with cnt_I=0 -> err_o=1 and stays 1; cnt_I stays 0.
- Assert rst_i while in HELD with cnt_D=3 -> mem_req_valid_o=0 immediately, counters 0, idle_o=1.

Source files
------------

// File: rtl/cva6_mem_req_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : cva6_mem_req_arbiter_if                                      |
// | Description : Bundle of request, memory-port and response signals for the |
// |               two-requester memory request arbiter. Signal suffixes keep   |
// |               the direction as seen from the arbiter.                      |
// |   slave  modport : arbiter side                                            |
// |   master modport : requesters + memory port side                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface cva6_mem_req_arbiter_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int TID_WIDTH  = 2
);
   // icache refill requests (read only)
   logic                  icache_req_valid_i;
   logic                  icache_req_ready_o;
   logic [ADDR_WIDTH-1:0] icache_req_addr_i;
   logic [TID_WIDTH-1:0]  icache_req_tid_i;
   // dcache miss / write-through requests
   logic                  dcache_req_valid_i;
   logic                  dcache_req_ready_o;
   logic [ADDR_WIDTH-1:0] dcache_req_addr_i;
   logic                  dcache_req_we_i;
   logic [DATA_WIDTH-1:0] dcache_req_wdata_i;
   logic [TID_WIDTH-1:0]  dcache_req_tid_i;
   // shared memory request port, id = {source, tid}
   logic                  mem_req_valid_o;
   logic                  mem_req_ready_i;
   logic [ADDR_WIDTH-1:0] mem_req_addr_o;
   logic                  mem_req_we_o;
   logic [DATA_WIDTH-1:0] mem_req_wdata_o;
   logic [TID_WIDTH:0]    mem_req_id_o;
   // memory responses and their routed copies
   logic                  mem_rsp_valid_i;
   logic [TID_WIDTH:0]    mem_rsp_id_i;
   logic [DATA_WIDTH-1:0] mem_rsp_data_i;
   logic                  icache_rsp_valid_o;
   logic [TID_WIDTH-1:0]  icache_rsp_tid_o;
   logic [DATA_WIDTH-1:0] icache_rsp_data_o;
   logic                  dcache_rsp_valid_o;
   logic [TID_WIDTH-1:0]  dcache_rsp_tid_o;
   logic [DATA_WIDTH-1:0] dcache_rsp_data_o;
   // status
   logic                  idle_o;
   logic                  err_o;

   modport slave (
      input  icache_req_valid_i, icache_req_addr_i, icache_req_tid_i,
      input  dcache_req_valid_i, dcache_req_addr_i, dcache_req_we_i,
      input  dcache_req_wdata_i, dcache_req_tid_i,
      input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_data_i,
      output icache_req_ready_o, dcache_req_ready_o,
      output mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_id_o,
      output icache_rsp_valid_o, icache_rsp_tid_o, icache_rsp_data_o,
      output dcache_rsp_valid_o, dcache_rsp_tid_o, dcache_rsp_data_o,
      output idle_o, err_o
   );

   modport master (
      output icache_req_valid_i, icache_req_addr_i, icache_req_tid_i,
      output dcache_req_valid_i, dcache_req_addr_i, dcache_req_we_i,
      output dcache_req_wdata_i, dcache_req_tid_i,
      output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_data_i,
      input  icache_req_ready_o, dcache_req_ready_o,
      input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_id_o,
      input  icache_rsp_valid_o, icache_rsp_tid_o, icache_rsp_data_o,
      input  dcache_rsp_valid_o, dcache_rsp_tid_o, dcache_rsp_data_o,
      input  idle_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/cva6_mem_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : cva6_mem_req_arbiter                                         |
// | Description : Arbitrates icache refill and dcache miss/write requests onto |
// |               one memory request port. One grant per cycle, registered in  |
// |               a one-entry output stage, tagged {source, tid}. Per-source   |
// |               outstanding counters throttle requesters; responses are      |
// |               routed back combinationally by id MSB.                       |
// | Ports       : clk_i  - clock, rising edge                                  |
// |               rst_i  - asynchronous active-high reset                      |
// |               bus    - cva6_mem_req_arbiter_if.slave (requests, memory     |
// |                        port, routed responses, idle_o, err_o)              |
// | Config      : CVA6_MEM_ARB_DCACHE_PRIO_EN - dcache always wins, no         |
// |               round-robin pointer. Undefined: round-robin.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cva6_mem_req_arbiter #(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 64,
   parameter int TID_WIDTH       = 2,
   parameter int MAX_OUTSTANDING = 7
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   cva6_mem_req_arbiter_if.slave  bus
);

   localparam int c_cnt_width = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [c_cnt_width-1:0] c_cnt_max = c_cnt_width'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_we;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [TID_WIDTH:0]      r_id;
   logic [c_cnt_width-1:0]  r_cnt_i;
   logic [c_cnt_width-1:0]  r_cnt_d;
   logic                    r_err;
`ifndef CVA6_MEM_ARB_DCACHE_PRIO_EN
   logic                    r_ptr;     // 0: icache preferred next, 1: dcache
`endif

   logic w_can_accept, w_cap_i, w_cap_d, w_elig_i, w_elig_d;
   logic w_win_i, w_win_d, w_ready_i, w_ready_d;
   logic w_grant_i, w_grant_d, w_grant, w_dec_i, w_dec_d, w_err_set;

   // The stage frees up in the same cycle the memory port takes the held request.
   assign w_can_accept = (r_state == ST_EMPTY) || bus.mem_req_ready_i;
   assign w_cap_i      = (r_cnt_i < c_cnt_max);
   assign w_cap_d      = (r_cnt_d < c_cnt_max);
   assign w_elig_i     = bus.icache_req_valid_i & w_cap_i;
   assign w_elig_d     = bus.dcache_req_valid_i & w_cap_d;

`ifdef CVA6_MEM_ARB_DCACHE_PRIO_EN
   assign w_win_d = w_elig_d;
   assign w_win_i = w_elig_i & ~w_elig_d;
`else
   assign w_win_i = w_elig_i & (~w_elig_d | ~r_ptr);
   assign w_win_d = w_elig_d & (~w_elig_i |  r_ptr);
`endif

   // A requester may also see ready while idle, provided the other side is not
   // competing for the slot.
   assign w_ready_i = ~rst_i & w_can_accept & w_cap_i & (w_win_i | ~bus.dcache_req_valid_i);
   assign w_ready_d = ~rst_i & w_can_accept & w_cap_d & (w_win_d | ~bus.icache_req_valid_i);
   assign w_grant_i = bus.icache_req_valid_i & w_ready_i;
   assign w_grant_d = bus.dcache_req_valid_i & w_ready_d;
   assign w_grant   = w_grant_i | w_grant_d;

   assign w_dec_i   = bus.mem_rsp_valid_i & ~bus.mem_rsp_id_i[TID_WIDTH];
   assign w_dec_d   = bus.mem_rsp_valid_i &  bus.mem_rsp_id_i[TID_WIDTH];
   // A response that arrives with nothing outstanding is a protocol error.
   assign w_err_set = (w_dec_i & ~w_grant_i & (r_cnt_i == '0)) |
                      (w_dec_d & ~w_grant_d & (r_cnt_d == '0));

   function automatic logic [c_cnt_width-1:0] f_cnt_next(
      input logic [c_cnt_width-1:0] cnt,
      input logic                   inc,
      input logic                   dec
   );
      logic [c_cnt_width-1:0] res;
      res = cnt;
      if (inc && !dec)
         res = cnt + c_cnt_width'(1);
      else if (dec && !inc && (cnt != '0))
         res = cnt - c_cnt_width'(1);
      return res;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_EMPTY;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_id    <= '0;
         r_cnt_i <= '0;
         r_cnt_d <= '0;
         r_err   <= 1'b0;
`ifndef CVA6_MEM_ARB_DCACHE_PRIO_EN
         r_ptr   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_grant)
                  r_state <= ST_HELD;
            end
            ST_HELD: begin
               if (bus.mem_req_ready_i && !w_grant)
                  r_state <= ST_EMPTY;
            end
            default: r_state <= ST_EMPTY;
         endcase

         // A grant only happens when the stage can accept, so loading here
         // never overwrites a request the memory port has not taken.
         if (w_grant) begin
            r_addr  <= w_grant_d ? bus.dcache_req_addr_i : bus.icache_req_addr_i;
            r_we    <= w_grant_d & bus.dcache_req_we_i;
            r_wdata <= w_grant_d ? bus.dcache_req_wdata_i : '0;
            r_id    <= w_grant_d ? {1'b1, bus.dcache_req_tid_i} : {1'b0, bus.icache_req_tid_i};
`ifndef CVA6_MEM_ARB_DCACHE_PRIO_EN
            r_ptr   <= w_grant_i;   // point at the requester that lost/was idle
`endif
         end

         r_cnt_i <= f_cnt_next(r_cnt_i, w_grant_i, w_dec_i);
         r_cnt_d <= f_cnt_next(r_cnt_d, w_grant_d, w_dec_d);
         if (w_err_set)
            r_err <= 1'b1;
      end
   end

   assign bus.icache_req_ready_o = w_ready_i;
   assign bus.dcache_req_ready_o = w_ready_d;
   assign bus.mem_req_valid_o    = (r_state == ST_HELD);
   assign bus.mem_req_addr_o     = r_addr;
   assign bus.mem_req_we_o       = r_we;
   assign bus.mem_req_wdata_o    = r_wdata;
   assign bus.mem_req_id_o       = r_id;

   assign bus.icache_rsp_valid_o = w_dec_i;
   assign bus.icache_rsp_tid_o   = bus.mem_rsp_id_i[TID_WIDTH-1:0];
   assign bus.icache_rsp_data_o  = bus.mem_rsp_data_i;
   assign bus.dcache_rsp_valid_o = w_dec_d;
   assign bus.dcache_rsp_tid_o   = bus.mem_rsp_id_i[TID_WIDTH-1:0];
   assign bus.dcache_rsp_data_o  = bus.mem_rsp_data_i;

   assign bus.idle_o = (r_state == ST_EMPTY) && (r_cnt_i == '0) && (r_cnt_d == '0);
   assign bus.err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cva6_mem_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_cva6_mem_req_arbiter                                      |
// | Description : Self-checking bench for cva6_mem_req_arbiter. Vector table   |
// |               for arbitration/routing, hand sequences for stall, limit,    |
// |               error and reset; request payloads checked by a scoreboard.   |
// |               Honors CVA6_MEM_ARB_DCACHE_PRIO_EN for the grant pattern.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cva6_mem_req_arbiter;

   logic clk;
   logic rst;

   cva6_mem_req_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TID_WIDTH(2)) bus ();

   cva6_mem_req_arbiter #(
      .ADDR_WIDTH(64), .DATA_WIDTH(64), .TID_WIDTH(2), .MAX_OUTSTANDING(7)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv, dv, mr, rv;
      logic [2:0] rid;
      logic       ir, dr, mv, idle, irv, drv;
   } vec_t;

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [2:0]  id;
   } req_t;

   vec_t  vecs[10];
   req_t  sb_q[$];
   logic  grant_log[$];
   int    n_checks = 0;
   int    n_errors = 0;

   function automatic vec_t mk(input int iv, dv, mr, rv, rid, ir, dr, mv, idle, irv, drv);
      vec_t m;
      m.iv = 1'(iv); m.dv = 1'(dv); m.mr = 1'(mr); m.rv = 1'(rv); m.rid = 3'(rid);
      m.ir = 1'(ir); m.dr = 1'(dr); m.mv = 1'(mv); m.idle = 1'(idle);
      m.irv = 1'(irv); m.drv = 1'(drv);
      return m;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_i(input logic v, input logic [63:0] a, input logic [1:0] t);
      bus.icache_req_valid_i = v;
      bus.icache_req_addr_i  = a;
      bus.icache_req_tid_i   = t;
   endtask

   task automatic set_d(input logic v, input logic [63:0] a, input logic we,
                        input logic [63:0] wd, input logic [1:0] t);
      bus.dcache_req_valid_i = v;
      bus.dcache_req_addr_i  = a;
      bus.dcache_req_we_i    = we;
      bus.dcache_req_wdata_i = wd;
      bus.dcache_req_tid_i   = t;
   endtask

   task automatic set_rsp(input logic v, input logic [2:0] id, input logic [63:0] d);
      bus.mem_rsp_valid_i = v;
      bus.mem_rsp_id_i    = id;
      bus.mem_rsp_data_i  = d;
   endtask

   // Called at the negedge with inputs stable: the handshakes seen here are the
   // ones the next rising edge commits.
   task automatic sb_sample();
      req_t e;
      logic ihs, dhs;
      if (rst) begin
         sb_q.delete();
         return;
      end
      ihs = bus.icache_req_valid_i & bus.icache_req_ready_o;
      dhs = bus.dcache_req_valid_i & bus.dcache_req_ready_o;
      chk("single_grant", 64'(ihs & dhs), 64'd0);
      if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got id %0h, expected no request", bus.mem_req_id_o);
         end else begin
            e = sb_q.pop_front();
            chk("sb_addr",  bus.mem_req_addr_o, e.addr);
            chk("sb_we",    64'(bus.mem_req_we_o), 64'(e.we));
            chk("sb_wdata", bus.mem_req_wdata_o, e.wdata);
            chk("sb_id",    64'(bus.mem_req_id_o), 64'(e.id));
         end
      end
      if (ihs) begin
         e.addr = bus.icache_req_addr_i; e.we = 1'b0; e.wdata = '0;
         e.id = {1'b0, bus.icache_req_tid_i};
         sb_q.push_back(e);
         grant_log.push_back(1'b0);
      end
      if (dhs) begin
         e.addr = bus.dcache_req_addr_i; e.we = bus.dcache_req_we_i;
         e.wdata = bus.dcache_req_wdata_i; e.id = {1'b1, bus.dcache_req_tid_i};
         sb_q.push_back(e);
         grant_log.push_back(1'b1);
      end
   endtask

   task automatic commit();
      sb_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_gl;

      // ---------------- vector table ----------------
`ifdef CVA6_MEM_ARB_DCACHE_PRIO_EN
      vecs[0] = mk(1,1,1,0,0, 0,1,0,1,0,0);
      vecs[1] = mk(1,1,1,0,0, 0,1,1,0,0,0);
      vecs[2] = mk(1,1,1,0,0, 0,1,1,0,0,0);
      vecs[3] = mk(1,1,1,0,0, 0,1,1,0,0,0);
      vecs[4] = mk(0,0,1,0,0, 1,1,1,0,0,0);
      vecs[5] = mk(0,0,1,1,4, 1,1,0,0,0,1);
      vecs[6] = mk(0,0,1,1,5, 1,1,0,0,0,1);
      vecs[7] = mk(0,0,1,1,6, 1,1,0,0,0,1);
      vecs[8] = mk(0,0,1,1,7, 1,1,0,0,0,1);
      vecs[9] = mk(0,0,1,0,0, 1,1,0,1,0,0);
      exp_gl  = 4'b1111;
`else
      vecs[0] = mk(1,1,1,0,0, 0,1,0,1,0,0);
      vecs[1] = mk(1,1,1,0,0, 1,0,1,0,0,0);
      vecs[2] = mk(1,1,1,0,0, 0,1,1,0,0,0);
      vecs[3] = mk(1,1,1,0,0, 1,0,1,0,0,0);
      vecs[4] = mk(0,0,1,0,0, 1,1,1,0,0,0);
      vecs[5] = mk(0,0,1,1,4, 1,1,0,0,0,1);
      vecs[6] = mk(0,0,1,1,5, 1,1,0,0,0,1);
      vecs[7] = mk(0,0,1,1,0, 1,1,0,0,1,0);
      vecs[8] = mk(0,0,1,1,1, 1,1,0,0,1,0);
      vecs[9] = mk(0,0,1,0,0, 1,1,0,1,0,0);
      exp_gl  = 4'b0101;   // D, I, D, I (index 0 first)
`endif

      // ---------------- reset state ----------------
      rst = 1'b1;
      set_i(1'b1, 64'h0, 2'd0);
      set_d(1'b1, 64'h0, 1'b0, 64'h0, 2'd0);
      set_rsp(1'b0, 3'd0, 64'h0);
      bus.mem_req_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_i_ready", 64'(bus.icache_req_ready_o), 64'd0);
      chk("rst_d_ready", 64'(bus.dcache_req_ready_o), 64'd0);
      chk("rst_mem_valid", 64'(bus.mem_req_valid_o), 64'd0);
      chk("rst_addr", bus.mem_req_addr_o, 64'd0);
      chk("rst_id", 64'(bus.mem_req_id_o), 64'd0);
      chk("rst_wdata", bus.mem_req_wdata_o, 64'd0);
      chk("rst_idle", 64'(bus.idle_o), 64'd1);
      chk("rst_err", 64'(bus.err_o), 64'd0);
      @(posedge clk); #1;
      set_i(1'b0, 64'h0, 2'd0);
      set_d(1'b0, 64'h0, 1'b0, 64'h0, 2'd0);
      rst = 1'b0;

      // ---------------- single icache request ----------------
      set_i(1'b1, 64'h8000_0000, 2'd1);
      bus.mem_req_ready_i = 1'b1;
      @(negedge clk);
      chk("t1_i_ready", 64'(bus.icache_req_ready_o), 64'd1);
      chk("t1_mem_valid_n", 64'(bus.mem_req_valid_o), 64'd0);
      commit();
      set_i(1'b0, 64'h0, 2'd0);
      @(negedge clk);
      chk("t1_mem_valid", 64'(bus.mem_req_valid_o), 64'd1);
      chk("t1_id", 64'(bus.mem_req_id_o), 64'h1);
      chk("t1_we", 64'(bus.mem_req_we_o), 64'd0);
      chk("t1_addr", bus.mem_req_addr_o, 64'h8000_0000);
      chk("t1_idle_busy", 64'(bus.idle_o), 64'd0);
      commit();
      set_rsp(1'b1, 3'b001, 64'hDEAD);
      @(negedge clk);
      chk("t1_idle_cnt", 64'(bus.idle_o), 64'd0);
      chk("t1_rsp_valid", 64'(bus.icache_rsp_valid_o), 64'd1);
      chk("t1_rsp_tid", 64'(bus.icache_rsp_tid_o), 64'd1);
      chk("t1_rsp_data", bus.icache_rsp_data_o, 64'hDEAD);
      chk("t1_d_rsp_valid", 64'(bus.dcache_rsp_valid_o), 64'd0);
      commit();
      set_rsp(1'b0, 3'd0, 64'h0);
      @(negedge clk);
      chk("t1_idle_back", 64'(bus.idle_o), 64'd1);
      commit();

      // ---------------- table-driven arbitration / routing ----------------
      grant_log.delete();
      for (int k = 0; k < 10; k++) begin
         set_i(vecs[k].iv, 64'h1000 + 64'(k * 8), 2'(k));
         set_d(vecs[k].dv, 64'h2000 + 64'(k * 8), k[0], 64'hD000 + 64'(k), 2'(k + 1));
         bus.mem_req_ready_i = vecs[k].mr;
         set_rsp(vecs[k].rv, vecs[k].rid, 64'hF00 + 64'(k));
         @(negedge clk);
         chk($sformatf("vec%0d_i_ready", k), 64'(bus.icache_req_ready_o), 64'(vecs[k].ir));
         chk($sformatf("vec%0d_d_ready", k), 64'(bus.dcache_req_ready_o), 64'(vecs[k].dr));
         chk($sformatf("vec%0d_mem_valid", k), 64'(bus.mem_req_valid_o), 64'(vecs[k].mv));
         chk($sformatf("vec%0d_idle", k), 64'(bus.idle_o), 64'(vecs[k].idle));
         chk($sformatf("vec%0d_i_rsp", k), 64'(bus.icache_rsp_valid_o), 64'(vecs[k].irv));
         chk($sformatf("vec%0d_d_rsp", k), 64'(bus.dcache_rsp_valid_o), 64'(vecs[k].drv));
         chk($sformatf("vec%0d_d_data", k), bus.dcache_rsp_data_o, 64'hF00 + 64'(k));
         commit();
      end
      set_rsp(1'b0, 3'd0, 64'h0);
      chk("grant_count", 64'(grant_log.size()), 64'd4);
      for (int g = 0; g < 4 && g < grant_log.size(); g++)
         chk($sformatf("grant_order%0d", g), 64'(grant_log[g]), 64'(exp_gl[g]));

      // ---------------- memory stall ----------------
      set_i(1'b1, 64'hA000, 2'd2);
      bus.mem_req_ready_i = 1'b0;
      @(negedge clk);
      chk("st_first_ready", 64'(bus.icache_req_ready_o), 64'd1);
      commit();
      set_i(1'b1, 64'hB000, 2'd3);
      set_d(1'b1, 64'hC000, 1'b1, 64'h1234, 2'd2);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk($sformatf("st%0d_valid", s), 64'(bus.mem_req_valid_o), 64'd1);
         chk($sformatf("st%0d_addr", s), bus.mem_req_addr_o, 64'hA000);
         chk($sformatf("st%0d_id", s), 64'(bus.mem_req_id_o), 64'h2);
         chk($sformatf("st%0d_i_ready", s), 64'(bus.icache_req_ready_o), 64'd0);
         chk($sformatf("st%0d_d_ready", s), 64'(bus.dcache_req_ready_o), 64'd0);
         commit();
      end
      bus.mem_req_ready_i = 1'b1;
      @(negedge clk);
      chk("st_rel_addr", bus.mem_req_addr_o, 64'hA000);
      chk("st_rel_d_ready", 64'(bus.dcache_req_ready_o), 64'd1);
      chk("st_rel_i_ready", 64'(bus.icache_req_ready_o), 64'd0);
      commit();
      set_d(1'b0, 64'h0, 1'b0, 64'h0, 2'd0);
      @(negedge clk);
      chk("st_d_addr", bus.mem_req_addr_o, 64'hC000);
      chk("st_d_we", 64'(bus.mem_req_we_o), 64'd1);
      chk("st_i_ready2", 64'(bus.icache_req_ready_o), 64'd1);
      commit();
      set_i(1'b0, 64'h0, 2'd0);
      @(negedge clk);
      chk("st_b_addr", bus.mem_req_addr_o, 64'hB000);
      commit();
      set_rsp(1'b1, 3'b010, 64'h1); commit();
      set_rsp(1'b1, 3'b011, 64'h2); commit();
      set_rsp(1'b1, 3'b110, 64'h3); commit();
      set_rsp(1'b0, 3'd0, 64'h0);
      @(negedge clk);
      chk("st_idle", 64'(bus.idle_o), 64'd1);
      commit();

      // ---------------- outstanding limit ----------------
      for (int k = 0; k < 7; k++) begin
         set_d(1'b1, 64'h3000 + 64'(k * 8), 1'b0, 64'h0, 2'(k));
         @(negedge clk);
         chk($sformatf("lim%0d_ready", k), 64'(bus.dcache_req_ready_o), 64'd1);
         commit();
      end
      set_d(1'b1, 64'h3100, 1'b0, 64'h0, 2'd3);
      @(negedge clk);
      chk("lim_full", 64'(bus.dcache_req_ready_o), 64'd0);
      commit();
      set_rsp(1'b1, 3'b100, 64'h0);
      @(negedge clk);
      chk("lim_same_cycle", 64'(bus.dcache_req_ready_o), 64'd0);
      commit();
      set_rsp(1'b0, 3'd0, 64'h0);
      @(negedge clk);
      chk("lim_reopen", 64'(bus.dcache_req_ready_o), 64'd1);
      commit();
      set_d(1'b0, 64'h0, 1'b0, 64'h0, 2'd0);
      for (int k = 0; k < 7; k++) begin
         set_rsp(1'b1, 3'b100, 64'h0);
         commit();
      end
      set_rsp(1'b0, 3'd0, 64'h0);
      @(negedge clk);
      chk("lim_idle", 64'(bus.idle_o), 64'd1);
      commit();

      // ---------------- error on spurious response ----------------
      set_rsp(1'b1, 3'b000, 64'h55);
      @(negedge clk);
      chk("err_before", 64'(bus.err_o), 64'd0);
      chk("err_routed", 64'(bus.icache_rsp_valid_o), 64'd1);
      commit();
      set_rsp(1'b0, 3'd0, 64'h0);
      @(negedge clk);
      chk("err_set", 64'(bus.err_o), 64'd1);
      chk("err_cnt_zero", 64'(bus.idle_o), 64'd1);
      commit();
      @(negedge clk);
      chk("err_sticky", 64'(bus.err_o), 64'd1);
      commit();

      // ---------------- reset while HELD with cnt_D = 3 ----------------
      set_d(1'b1, 64'h4000, 1'b0, 64'h0, 2'd0); commit();
      set_d(1'b1, 64'h4008, 1'b0, 64'h0, 2'd1); commit();
      set_d(1'b1, 64'h4010, 1'b0, 64'h0, 2'd2); commit();
      set_d(1'b0, 64'h0, 1'b0, 64'h0, 2'd0);
      bus.mem_req_ready_i = 1'b0;
      @(negedge clk);
      chk("rr_held", 64'(bus.mem_req_valid_o), 64'd1);
      chk("rr_busy", 64'(bus.idle_o), 64'd0);
      #1 rst = 1'b1;
      #1;
      chk("rr_mem_valid", 64'(bus.mem_req_valid_o), 64'd0);
      chk("rr_idle", 64'(bus.idle_o), 64'd1);
      chk("rr_d_ready", 64'(bus.dcache_req_ready_o), 64'd0);
      chk("rr_err", 64'(bus.err_o), 64'd0);
      chk("rr_addr", bus.mem_req_addr_o, 64'd0);
      sb_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rr_after_idle", 64'(bus.idle_o), 64'd1);
      chk("rr_after_valid", 64'(bus.mem_req_valid_o), 64'd0);
      commit();

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
